// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack.
// Handles sequential, branch, jump, call and return flow, optional
// destination alignment, and sticky overflow/underflow/misalign flags.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      ALIGN        = 2,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic [2:0]                         op,
    input  logic [WIDTH-1:0]                   target,
    input  logic [WIDTH-1:0]                   offset,
    output logic [WIDTH-1:0]                   pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic                               ras_full,
    output logic                               ras_empty,
    output logic                               ras_ovf,
    output logic                               ras_unf,
    output logic                               misalign
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_SEQ    = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_JUMP   = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    // Low PC bits that must be zero; all-zero mask when alignment is disabled.
    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN) - WIDTH'(1);

    // pc_q carries a declaration initialiser so it holds RESET_VECTOR before the first reset.
    logic [WIDTH-1:0] pc_q = RESET_VECTOR;
    logic [WIDTH-1:0] pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             mis_q, mis_d;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] dest;
    logic             check_align;
    logic             push_en;
    logic [PTR_W-1:0] wp_next;
    logic [PTR_W-1:0] wp_prev;
    logic             stack_full;
    logic             stack_empty;

    assign pc_inc      = pc_q + WIDTH'(INC);
    assign stack_full  = (count_q == CNT_W'(RAS_DEPTH));
    assign stack_empty = (count_q == '0);

    // Write pointer wraps at RAS_DEPTH so overflow overwrites the oldest entry.
    assign wp_next = (wp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
    assign wp_prev = (wp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : wp_q - PTR_W'(1);

    // Next-state computation for pc, stack bookkeeping and sticky flags.
    always_comb begin
        dest        = pc_q;
        check_align = 1'b0;
        push_en     = 1'b0;
        count_d     = count_q;
        wp_d        = wp_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        mis_d       = mis_q;

        case (op)
            OP_HOLD: dest = pc_q;
            OP_SEQ:  dest = pc_inc;
            OP_BRANCH: begin
                dest        = pc_q + offset;
                check_align = 1'b1;
            end
            OP_JUMP: begin
                dest        = target;
                check_align = 1'b1;
            end
            OP_CALL: begin
                dest        = target;
                check_align = 1'b1;
                push_en     = 1'b1;
                wp_d        = wp_next;
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_RET: begin
                if (!stack_empty) begin
                    dest        = ras_q[wp_prev];
                    check_align = 1'b1;
                    wp_d        = wp_prev;
                    count_d     = count_q - CNT_W'(1);
                end else begin
                    // Empty stack: fall through as a sequential step.
                    dest  = pc_inc;
                    unf_d = 1'b1;
                end
            end
            default: dest = pc_q;
        endcase

        pc_d = dest;
        if (check_align) begin
            pc_d = dest & ~ALIGN_MASK;
            if (|(dest & ALIGN_MASK)) begin
                mis_d = 1'b1;
            end
        end
    end

    // Control state: reset wins, stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
            wp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else if (!stall) begin
            pc_q    <= pc_d;
            count_q <= count_d;
            wp_q    <= wp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            mis_q   <= mis_d;
        end
    end

    // Stack storage; contents are not reset and are only reachable via count_q.
    always_ff @(posedge clk) begin
        if (!rst && !stall && push_en) begin
            ras_q[wp_q] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign ras_count = count_q;
    assign ras_full  = stack_full;
    assign ras_empty = stack_empty;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;
    assign misalign  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors plus randomized traffic checked
// against a queue-based reference model.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  op;
    logic [31:0] target;
    logic [31:0] offset;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_full;
    logic        ras_empty;
    logic        ras_ovf;
    logic        ras_unf;
    logic        misalign;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model state
    logic [31:0] pc_m = 32'h0;
    logic [31:0] stk[$];
    logic        ovf_m = 1'b0;
    logic        unf_m = 1'b0;
    logic        mis_m = 1'b0;

    pc_sequencer #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .ALIGN(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target),
        .offset(offset), .pc(pc), .ras_count(ras_count), .ras_full(ras_full),
        .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
        .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Aligned load of a redirect destination
    task automatic model_redirect(input logic [31:0] dst);
        if (dst[1:0] != 2'b00) mis_m = 1'b1;
        pc_m = {dst[31:2], 2'b00};
    endtask

    task automatic model_update(input logic r, input logic s, input logic [2:0] o,
                                input logic [31:0] t, input logic [31:0] f);
        if (r) begin
            pc_m = 32'h0;
            stk.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
            mis_m = 1'b0;
        end else if (!s) begin
            case (o)
                3'd1: pc_m = pc_m + 32'd4;
                3'd2: model_redirect(pc_m + f);
                3'd3: model_redirect(t);
                3'd4: begin
                    if (stk.size() == 4) begin
                        void'(stk.pop_front());
                        ovf_m = 1'b1;
                    end
                    stk.push_back(pc_m + 32'd4);
                    model_redirect(t);
                end
                3'd5: begin
                    if (stk.size() > 0) begin
                        model_redirect(stk.pop_back());
                    end else begin
                        pc_m  = pc_m + 32'd4;
                        unf_m = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("pc", 64'(pc), 64'(pc_m));
        check_eq("ras_count", 64'(ras_count), 64'(stk.size()));
        check_eq("ras_full", 64'(ras_full), 64'(stk.size() == 4));
        check_eq("ras_empty", 64'(ras_empty), 64'(stk.size() == 0));
        check_eq("ras_ovf", 64'(ras_ovf), 64'(ovf_m));
        check_eq("ras_unf", 64'(ras_unf), 64'(unf_m));
        check_eq("misalign", 64'(misalign), 64'(mis_m));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after.
    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic [31:0] t, input logic [31:0] f);
        rst = r; stall = s; op = o; target = t; offset = f;
        @(posedge clk);
        model_update(r, s, o, t, f);
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] t;
        logic [31:0] f;
        logic [2:0]  o;
        int          v;

        rst = 1'b0; stall = 1'b0; op = 3'd0; target = '0; offset = '0;
        #1;
        check_eq("pc_time_zero", 64'(pc), 64'h0);

        // Reset then sequential stepping, then stall
        step(1'b1, 1'b0, 3'd1, 32'h0, 32'h0);
        check_eq("rst_pc", 64'(pc), 64'h0);
        step(1'b0, 1'b0, 3'd1, 32'h0, 32'h0);
        step(1'b0, 1'b0, 3'd1, 32'h0, 32'h0);
        step(1'b0, 1'b0, 3'd1, 32'h0, 32'h0);
        check_eq("seq_pc", 64'(pc), 64'hC);
        step(1'b0, 1'b1, 3'd1, 32'h0, 32'h0);
        step(1'b0, 1'b1, 3'd4, 32'h500, 32'h0);
        check_eq("stall_pc", 64'(pc), 64'hC);

        // Branch backwards, jump to top of range, wrap on SEQ
        step(1'b0, 1'b0, 3'd3, 32'h100, 32'h0);
        step(1'b0, 1'b0, 3'd2, 32'h0, 32'hFFFF_FFF0);
        check_eq("branch_pc", 64'(pc), 64'hF0);
        step(1'b0, 1'b0, 3'd3, 32'hFFFF_FFFC, 32'h0);
        check_eq("jump_top_pc", 64'(pc), 64'hFFFF_FFFC);
        step(1'b0, 1'b0, 3'd1, 32'h0, 32'h0);
        check_eq("wrap_pc", 64'(pc), 64'h0);
        check_eq("wrap_noflag", 64'({ras_ovf, ras_unf, misalign}), 64'h0);

        // Call / return pair
        step(1'b0, 1'b0, 3'd3, 32'h10, 32'h0);
        step(1'b0, 1'b0, 3'd4, 32'h200, 32'h0);
        check_eq("call_pc", 64'(pc), 64'h200);
        check_eq("call_cnt", 64'(ras_count), 64'd1);
        step(1'b0, 1'b0, 3'd5, 32'h0, 32'h0);
        check_eq("ret_pc", 64'(pc), 64'h14);
        check_eq("ret_empty", 64'(ras_empty), 64'd1);

        // Stack overflow then drain past empty
        step(1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd4, pc + 32'h100, 32'h0);
        check_eq("ovf_flag", 64'(ras_ovf), 64'd1);
        check_eq("ovf_full", 64'(ras_full), 64'd1);
        check_eq("ovf_cnt", 64'(ras_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 3'd5, 32'h0, 32'h0);
            check_eq("lifo_pc", 64'(pc), 64'(32'h404 - 32'(i) * 32'h100));
        end
        step(1'b0, 1'b0, 3'd5, 32'h0, 32'h0);
        check_eq("unf_pc", 64'(pc), 64'h108);
        check_eq("unf_flag", 64'(ras_unf), 64'd1);

        // Misaligned jump, then reset concurrent with CALL
        step(1'b0, 1'b0, 3'd3, 32'h203, 32'h0);
        check_eq("mis_pc", 64'(pc), 64'h200);
        check_eq("mis_flag", 64'(misalign), 64'd1);
        step(1'b1, 1'b0, 3'd4, 32'h800, 32'h0);
        check_eq("rst_call_pc", 64'(pc), 64'h0);
        check_eq("rst_call_state", 64'({ras_count, ras_ovf, ras_unf, misalign}), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            v = int'($urandom_range(0, 11));
            if (v >= 10)     o = 3'd5;
            else if (v >= 8) o = 3'd4;
            else             o = 3'(v);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            f = 32'($signed(32'($urandom_range(0, 1024))) - 32'sd512);
            if ($urandom_range(0, 3) != 0) f[1:0] = 2'b00;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0), o, t, f);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
